// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request/response bundle between the memory stage (master) and the lsu (slave)
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit with byte/halfword read-modify-write over a word-only DMEM
// Optional LSU_MISALIGN_TRAP_EN: misaligned legal accesses report resp_err instead of aligning down.
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  lsu_if.slave        bus,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        legal;
  logic        req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    legal = 1'b0;
    if (bus.req_we) begin
      legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
              (bus.req_funct3 == 3'b010);
    end else begin
      case (bus.req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign req_err = !legal || misaligned;
`else
  assign req_err = !legal;
`endif

  // Lane select ignores the low address bits below the access size, which aligns down.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = dmem_rdata[7:0];
      2'd1:    lane_b = dmem_rdata[15:8];
      2'd2:    lane_b = dmem_rdata[23:16];
      default: lane_b = dmem_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'd0, lane_b};
      3'b101:  load_val = {16'd0, lane_h};
      default: load_val = dmem_rdata;
    endcase
  end

  always_comb begin
    merged = old_q;
    case (f3_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    merged[7:0]   = wdata_q[7:0];
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      old_q   <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            old_q   <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= req_err;
            if (req_err)
              state <= S_RESP;
            else if (bus.req_we && (bus.req_funct3 == 3'b010))
              state <= S_WRITE;
            else
              state <= S_READ;
          end
        end
        S_READ: begin
          if (we_q) begin
            old_q <= dmem_rdata;
            state <= S_WRITE;
          end else begin
            rdata_q <= load_val;
            state   <= S_RESP;
          end
        end
        S_WRITE: state <= S_RESP;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_err   = (state == S_RESP) && err_q;
  assign bus.resp_rdata = (state == S_RESP) ? rdata_q : 32'd0;
  assign dmem_we        = (state == S_WRITE);
  assign dmem_wdata     = (state == S_WRITE) ? merged : 32'd0;
  assign dmem_addr      = (state == S_IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed bench for lsu with a reference memory model and per-cycle output checks
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic [31:0] dmem [0:255];
  logic [31:0] ref_mem [0:255];

  lsu_if bus();

  lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dmem_we) dmem[dmem_addr[9:2]] <= dmem_wdata;
  assign dmem_rdata = dmem[dmem_addr[9:2]];

  int checks = 0;
  int errors = 0;

  int          exp_lat;
  logic        exp_err;
  logic        exp_write;
  logic [31:0] exp_rdata;
  logic [31:0] exp_wdata;
  logic [31:0] exp_addr;
  bit          tr_active = 1'b0;
  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;
  int          cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the access size, legality and byte offset arithmetic.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    int          size;
    int          off;
    bit          legal;
    bit          mis;
    logic [31:0] word;
    logic [31:0] mask;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
    mis   = (addr % size) != 0;
    exp_err = !legal;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) exp_err = 1'b1;
`else
    if (mis) exp_err = exp_err;
`endif
    exp_addr  = addr & ~32'd3;
    exp_rdata = 32'd0;
    exp_wdata = 32'd0;
    exp_write = 1'b0;
    exp_lat   = 1;
    if (!exp_err) begin
      word = ref_mem[addr[9:2]];
      off  = ((addr % 4) / size) * size;
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      if (!we) begin
        exp_lat   = 2;
        exp_rdata = (word >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && exp_rdata[8 * size - 1]) exp_rdata = exp_rdata | ~mask;
      end else begin
        exp_lat   = (size == 4) ? 2 : 3;
        exp_write = 1'b1;
        exp_wdata = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0;
    end else if (tr_active) begin
      cyc++;
      check("resp_valid", 32'(bus.resp_valid), 32'(cyc == exp_lat));
      check("req_ready_busy", 32'(bus.req_ready), 32'd0);
      check("dmem_we", 32'(dmem_we), 32'(exp_write && cyc == exp_lat - 1));
      check("dmem_wdata", dmem_wdata, (exp_write && cyc == exp_lat - 1) ? exp_wdata : 32'd0);
      check("dmem_addr", dmem_addr, exp_addr);
      check("resp_err", 32'(bus.resp_err), (cyc == exp_lat) ? 32'(exp_err) : 32'd0);
      check("resp_rdata", bus.resp_rdata, (cyc == exp_lat) ? exp_rdata : 32'd0);
      if (bus.resp_valid) begin
        last_rdata = bus.resp_rdata;
        last_err   = bus.resp_err;
      end
    end else begin
      cyc = 0;
      check("idle_req_ready", 32'(bus.req_ready), 32'd1);
      check("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("idle_resp_err", 32'(bus.resp_err), 32'd0);
      check("idle_resp_rdata", bus.resp_rdata, 32'd0);
      check("idle_dmem_we", 32'(dmem_we), 32'd0);
      check("idle_dmem_addr", dmem_addr, 32'd0);
      check("idle_dmem_wdata", dmem_wdata, 32'd0);
    end
  end

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd);
    model(we, f3, addr, wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = 32'h5A5A_5A5A;
    tr_active = 1'b1;
    repeat (exp_lat) @(posedge clk);
    #1;
    tr_active = 1'b0;
    if (exp_write) ref_mem[exp_addr[9:2]] = exp_wdata;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    check("mem4_sw", dmem[4], 32'hDEAD_BEEF);
    req(1'b0, 3'b010, 32'h10, 32'd0);
    check("lw_0x10", last_rdata, 32'hDEAD_BEEF);

    req(1'b1, 3'b010, 32'h20, 32'h1122_3344);
    req(1'b1, 3'b000, 32'h22, 32'h0000_00AB);
    check("mem8_sb", dmem[8], 32'h11AB_3344);
    req(1'b1, 3'b000, 32'h13, 32'h0000_0077);
    check("mem4_sb_lane3", dmem[4], 32'h77AD_BEEF);

    req(1'b1, 3'b010, 32'h30, 32'h8001_F0FF);
    req(1'b0, 3'b000, 32'h30, 32'd0);
    check("lb_0x30", last_rdata, 32'hFFFF_FFFF);
    req(1'b0, 3'b100, 32'h30, 32'd0);
    check("lbu_0x30", last_rdata, 32'h0000_00FF);
    req(1'b0, 3'b001, 32'h32, 32'd0);
    check("lh_0x32", last_rdata, 32'hFFFF_8001);
    req(1'b0, 3'b101, 32'h32, 32'd0);
    check("lhu_0x32", last_rdata, 32'h0000_8001);
    req(1'b0, 3'b000, 32'h33, 32'd0);
    check("lb_0x33", last_rdata, 32'hFFFF_FF80);
    req(1'b0, 3'b100, 32'h31, 32'd0);
    check("lbu_0x31", last_rdata, 32'h0000_00F0);

    req(1'b1, 3'b010, 32'h40, 32'hCAFE_F00D);
    req(1'b0, 3'b010, 32'h41, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_0x41_err", 32'(last_err), 32'd1);
`else
    check("lw_0x41_data", last_rdata, 32'hCAFE_F00D);
    check("lw_0x41_err", 32'(last_err), 32'd0);
`endif
    req(1'b1, 3'b001, 32'h43, 32'h0000_1234);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mem16_sh_mis", dmem[16], 32'hCAFE_F00D);
`else
    check("mem16_sh_mis", dmem[16], 32'h1234_F00D);
`endif
    req(1'b1, 3'b001, 32'h40, 32'h0000_BEEF);
    check("mem16_sh_lo", dmem[16], ref_mem[16]);

    req(1'b0, 3'b011, 32'h10, 32'd0);
    check("ill_load_err", 32'(last_err), 32'd1);
    check("ill_load_rdata", last_rdata, 32'd0);
    req(1'b1, 3'b100, 32'h10, 32'h1234_5678);
    check("ill_store_err", 32'(last_err), 32'd1);
    check("ill_store_mem", dmem[4], 32'h77AD_BEEF);

    req(1'b1, 3'b010, 32'h50, 32'h0BAD_CAFE);
    req(1'b0, 3'b010, 32'h50, 32'd0);
    check("st_ld_same_word", last_rdata, 32'h0BAD_CAFE);

    // Abort an SB while it is in READ: no write, no response, unit comes back ready.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h21;
    bus.req_wdata  = 32'h0000_00EE;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_dmem_we", 32'(dmem_we), 32'd0);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_mem8", dmem[8], 32'h11AB_3344);
    check("abort_ready_after", 32'(bus.req_ready), 32'd1);
    req(1'b0, 3'b010, 32'h20, 32'd0);
    check("lw_after_abort", last_rdata, 32'h11AB_3344);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core's memory stage and the word-addressed data memory (`DMEM`, 256 × 32-bit, combinational read, write on `posedge clk`). It accepts one RV32I load/store request at a time through a valid/ready handshake. It performs sign/zero extension for loads and read-modify-write for byte/halfword stores, since `DMEM` only writes whole words. It returns one response per accepted request.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width code.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: request rejected; no memory write occurred.
- `dmem_we` out 1: to `DMEM.mem_write`.
- `dmem_addr` out 32: to `DMEM.address`, always `{addr[31:2],2'b00}`.
- `dmem_wdata` out 32: to `DMEM.write_data`.
- `dmem_rdata` in 32: from `DMEM.read_data`, combinational.

## Operation
- Handshake:
  - A request is accepted on a rising edge with `req_valid && req_ready`.
  - `req_we`, `req_funct3`, `req_addr` and `req_wdata` are latched on acceptance.
  - Inputs are ignored outside IDLE.
- Legal loads (funct3): 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores (funct3): 000 SB, 001 SH, 010 SW.
- Any other code is illegal and produces `resp_err`.
- Misalignment: a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE → RESP if the request is illegal or misaligned (error path).
  - IDLE → READ for a load or for SB/SH.
  - IDLE → WRITE for SW.
  - READ → RESP for a load; the lane-selected, extended `dmem_rdata` is captured into `resp_rdata`.
  - READ → WRITE for SB/SH; the old word is captured.
  - WRITE → RESP.
  - RESP → IDLE unconditionally.
- Lane selection:
  - Byte lane is `addr[1:0]` (lane 0 = bits 7:0, little-endian).
  - Halfword lane is `addr[1]`.
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
- Store merge:
  - SB replaces only the addressed byte of the captured old word with `req_wdata[7:0]`.
  - SH replaces only the addressed halfword with `req_wdata[15:0]`.
  - SW writes `req_wdata` unmodified.
- `dmem_we` is high only in WRITE.
- `dmem_wdata` is the merged word in WRITE and 0 otherwise.
- `dmem_addr` is driven from the latched address in READ/WRITE/RESP and is 0 in IDLE.
- `resp_valid` is high only in RESP.
- `resp_err` and `resp_rdata` are valid only while `resp_valid` is high, and are 0 otherwise.

## Timing
- Reset values:
  - State is IDLE.
  - `req_ready` = 1.
  - `resp_valid`, `resp_err`, `resp_rdata`, `dmem_we`, `dmem_addr` and `dmem_wdata` are 0.
  - Internal latches are cleared.
- Latency is counted in cycles after the accepting edge. The cycle containing `resp_valid` is:
  - error: cycle 1;
  - load: cycle 2;
  - SW: cycle 2;
  - SB/SH: cycle 3.
- Throughput: the next request can be accepted at the end of the RESP cycle + 1, i.e. in IDLE only. Back-to-back requests are spaced by at least one idle cycle.
- Store-then-load to the same word: the load's READ observes the stored value, because the `DMEM` write lands at the end of WRITE.
- Reset asserted mid-operation:
  - Immediately returns to IDLE and drops `dmem_we` asynchronously.
  - No response is issued for the aborted request.
  - A write is suppressed unless it already completed on an earlier edge.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned legal request takes the error path.
  - `resp_err`=1 in cycle 1 and no `DMEM` access occurs.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Misaligned addresses are silently aligned down: a halfword uses `addr[1]`, a word ignores `addr[1:0]`. The access then proceeds normally.
  - `resp_err` is asserted only for illegal funct3.

## Test plan
- Reset and word store/load:
  - Stimulus: SW addr 0x10, data 0xDEADBEEF; then LW addr 0x10.
  - Required: `dmem_we` high for exactly one cycle; `memory[4]`=0xDEADBEEF; load `resp_rdata`=0xDEADBEEF in cycle 2.
- Byte RMW:
  - Stimulus: word 0x11223344 at 0x20; SB addr 0x22, data 0xAB.
  - Required: `memory[8]`=0x11AB3344; `resp_valid` in cycle 3.
- Extension:
  - Stimulus: word 0x8001F0FF at 0x30.
  - Required:
    - LB 0x30 → 0xFFFFFFFF;
    - LBU 0x30 → 0x000000FF;
    - LH 0x32 → 0xFFFF8001;
    - LHU 0x32 → 0x00008001.
- Misaligned:
  - Stimulus: LW 0x41.
  - Required with the macro: `resp_err`=1 in cycle 1, no write.
  - Required without the macro: reads the word at 0x40, `resp_err`=0.
  - Stimulus: SH 0x43 with the macro.
  - Required: memory unchanged.
- Illegal funct3:
  - Stimulus: load with funct3 011, and store with funct3 100.
  - Required: `resp_err`=1, `resp_rdata`=0, `dmem_we` never asserted.
- Reset abort:
  - Stimulus: assert `rst_n`=0 during READ of an SB.
  - Required: no response pulse, memory word unchanged, `req_ready`=1 after release.
